regfile_scan_bridge: RTL

- Serial scan-chain initiator for the 8x8 register file: a JTAG-style data register shifted in/out one bit per strobe, then executed as one register-file write or read on an update strobe.
- Sits between the TAP data-register path (shift/update strobes already synchronised to clk) and the register file's write port and one read port.
- Read results are loaded back into the scan register so the host shifts them out on the next scan.

---
 rtl/regfile_scan_bridge_pkg.sv | 20 ++
 rtl/regfile_scan_bridge_scan_shift_reg.sv | 45 ++++
 rtl/regfile_scan_bridge.sv | 119 +++++++++++
 3 files changed

// File: rtl/regfile_scan_bridge_pkg.sv
// Shared types and frame layout for the register-file scan bridge.
// A frame is op, then address, then data, sent LSB-first.
package regfile_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int OP_BIT   = 0;
   localparam int ADDR_LSB = 1;
   localparam int DATA_LSB = 4;

   localparam int FRAME_W = 12;

endpackage

// File: rtl/regfile_scan_bridge_scan_shift_reg.sv
// Scan data register: LSB-first shift path, saturating bit counter and a
// parallel load of read data into the data field.
module scan_shift_reg
   import regfile_scan_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int FRAME_W = 12
) (
   input  logic                               clk,
   input  logic                               srst_n,
   input  logic                               shift_en,
   input  logic                               tdi,
   input  logic                               load_en,
   input  logic [DATA_W-1:0]                  load_data,
   input  logic                               clr_cnt,
   output logic [FRAME_W-1:0]                 scan_q,
   output logic [$clog2(FRAME_W + 1)-1:0]     bit_cnt,
   output logic                               tdo
);

   localparam int CNT_W = $clog2(FRAME_W + 1);

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         scan_q  <= '0;
         bit_cnt <= '0;
      end else begin
         // Data sits in the top field, so a load never disturbs op/address.
         if (shift_en) begin
            scan_q <= {tdi, scan_q[FRAME_W-1:1]};
         end else if (load_en) begin
            scan_q[FRAME_W-1 -: DATA_W] <= load_data;
         end

         if (clr_cnt) begin
            bit_cnt <= '0;
         end else if (shift_en && (bit_cnt != CNT_W'(FRAME_W))) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

   assign tdo = scan_q[0];

endmodule

// File: rtl/regfile_scan_bridge.sv
// Scan-chain initiator for the 8x8 register file: shifts a frame in, then
// executes it as one write or one read whose result lands back in the chain.
module regfile_scan_bridge
   import regfile_scan_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              srst_n,
   input  logic              shift_en,
   input  logic              tdi,
   input  logic              update,
   output logic              tdo,
   output logic              reg_write,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic              busy,
   output logic              done,
   output logic              frame_err
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   state_e             state;
   logic               reg_write_q;
   logic               err_q;
   logic [FRAME_W-1:0] scan_q;
   logic [CNT_W-1:0]   bit_cnt;
   logic               shift_go;
   logic               load_go;
   logic               clr_cnt;
   logic               frame_full;
   logic               is_write;

   // Update has priority over a coincident shift; both are ignored while busy.
   assign shift_go   = (state == IDLE) && shift_en && !update;
   assign is_write   = (scan_q[OP_BIT] == OP_WRITE);
   assign load_go    = (state == EXEC) && !is_write;
   assign clr_cnt    = (state == DONE);
   assign frame_full = (bit_cnt == CNT_W'(FRAME_W));

   scan_shift_reg #(
      .DATA_W  (DATA_W),
      .FRAME_W (FRAME_W)
   ) u_scan (
      .clk       (clk),
      .srst_n    (srst_n),
      .shift_en  (shift_go),
      .tdi       (tdi),
      .load_en   (load_go),
      .load_data (r_data),
      .clr_cnt   (clr_cnt),
      .scan_q    (scan_q),
      .bit_cnt   (bit_cnt),
      .tdo       (tdo)
   );

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         state       <= IDLE;
         reg_write_q <= 1'b0;
         w_addr      <= '0;
         w_data      <= '0;
         r_addr      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_err   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         reg_write_q <= 1'b0;
         done        <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (update) begin
                  busy <= 1'b1;
                  if (frame_full) begin
                     state <= EXEC;
                     if (is_write) begin
                        reg_write_q <= 1'b1;
                        w_addr      <= scan_q[ADDR_LSB +: ADDR_W];
                        w_data      <= scan_q[DATA_LSB +: DATA_W];
                     end else begin
                        r_addr <= scan_q[ADDR_LSB +: ADDR_W];
                     end
                  end else begin
                     state     <= DONE;
                     err_q     <= 1'b1;
                     done      <= 1'b1;
                     frame_err <= 1'b1;
                  end
               end
            end
            EXEC: begin
               state     <= DONE;
               done      <= 1'b1;
               frame_err <= err_q;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               err_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Gating with reset keeps a write pending in EXEC from landing in a reset cycle.
   assign reg_write = reg_write_q & srst_n;

endmodule
